// File: rtl/interval_pkg.sv
// Shared types and helpers for the interval meter: time-base width, modular
// interval arithmetic and the readout FSM states.
package interval_pkg;

  localparam int unsigned DEF_TIME_W = 20;

  typedef logic [DEF_TIME_W-1:0] time_t;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift,
    StDone
  } rd_state_e;

  // Modular difference now - then, truncated to the given time-base width.
  function automatic logic [31:0] time_delta(logic [31:0] now_v, logic [31:0] then_v,
                                             int unsigned width);
    logic [31:0] mask;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (now_v - then_v) & mask;
  endfunction

  // Ties count as better so the most recent equal interval is kept.
  function automatic logic is_better(logic [31:0] cand, logic [31:0] cur);
    return cand <= cur;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter, one input bit per cycle, with a sticky
// overflow flag and all-9s saturation when the value exceeds DIGITS digits.
module bin2bcd_seq
  import interval_pkg::*;
#(
  parameter int unsigned IN_W   = 20,
  parameter int unsigned DIGITS = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [IN_W-1:0]       din_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  ovf_o,
  output logic [4*DIGITS-1:0]   bcd_o
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(IN_W + 1);

  rd_state_e       state_q, state_d;
  logic [IN_W-1:0] bin_q, bin_d;
  logic [BcdW-1:0] bcd_q, bcd_d, adj;
  logic            ovf_q, ovf_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          bin_d   = din_i;
          state_d = StLoad;
        end
      end
      StLoad: begin
        bcd_d   = '0;
        ovf_d   = 1'b0;
        cnt_d   = '0;
        state_d = StShift;
      end
      StShift: begin
        // Any bit leaving the top digit means the value needs more digits.
        ovf_d = ovf_q | adj[BcdW-1];
        bcd_d = {adj[BcdW-2:0], bin_q[IN_W-1]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(IN_W - 1)) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      bin_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o = (state_q != StIdle);
  assign done_o = (state_q == StDone);
  assign ovf_o  = ovf_q;
  assign bcd_o  = ovf_q ? {DIGITS{4'h9}} : bcd_q;

endmodule

// File: rtl/interval_meter.sv
// Multi-channel event-interval meter: timestamps rising edges, keeps the
// shortest interval per channel and converts a chosen channel to BCD.
module interval_meter
  import interval_pkg::*;
#(
  parameter int unsigned TIME_W = DEF_TIME_W,
  parameter int unsigned N_CH   = 4,
  parameter int unsigned DIGITS = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick,
  input  logic [N_CH-1:0]          evt,
  input  logic                     clr,
  input  logic                     rd_req,
  input  logic [$clog2(N_CH)-1:0]  rd_ch,
  output logic                     rd_busy,
  output logic                     rd_valid,
  output logic [4*DIGITS-1:0]      rd_bcd,
  output logic                     rd_ovf,
  output logic                     rd_empty,
  output logic [N_CH*TIME_W-1:0]   best,
  output logic [N_CH-1:0]          best_vld
);

  logic [TIME_W-1:0] now_q;

  always_ff @(posedge clk) begin
    if (rst)       now_q <= '0;
    else if (tick) now_q <= now_q + 1'b1;
  end

  for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
    logic              prev_q, armed_q, vld_q, rise;
    logic [TIME_W-1:0] last_q, best_q, delta;

    assign rise  = evt[i] & ~prev_q;
    assign delta = TIME_W'(time_delta(32'(now_q), 32'(last_q), TIME_W));

    always_ff @(posedge clk) begin
      if (rst) begin
        prev_q  <= 1'b0;
        armed_q <= 1'b0;
        vld_q   <= 1'b0;
        last_q  <= '0;
        best_q  <= '0;
      end else begin
        prev_q <= evt[i];
        // clr discards same-cycle edges; prev still tracks the input level.
        if (clr) begin
          armed_q <= 1'b0;
          vld_q   <= 1'b0;
          best_q  <= '0;
        end else if (rise) begin
          last_q  <= now_q;
          armed_q <= 1'b1;
          if (armed_q && (!vld_q || is_better(32'(delta), 32'(best_q)))) begin
            best_q <= delta;
            vld_q  <= 1'b1;
          end
        end
      end
    end

    assign best[i*TIME_W +: TIME_W] = best_q;
    assign best_vld[i]              = vld_q;
  end

  logic              sel_vld, start, empty_q;
  logic [TIME_W-1:0] sel_best, sel_din;

  always_comb begin
    sel_vld  = 1'b0;
    sel_best = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (i == int'(rd_ch)) begin
        sel_vld  = best_vld[i];
        sel_best = best[i*TIME_W +: TIME_W];
      end
    end
  end

  // Empty channels convert zero so latency stays fixed and the result is 0.
  assign start   = rd_req & ~rd_busy;
  assign sel_din = sel_vld ? sel_best : '0;

  always_ff @(posedge clk) begin
    if (rst)        empty_q <= 1'b0;
    else if (start) empty_q <= ~sel_vld;
  end

  bin2bcd_seq #(
    .IN_W   (TIME_W),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .din_i   (sel_din),
    .busy_o  (rd_busy),
    .done_o  (rd_valid),
    .ovf_o   (rd_ovf),
    .bcd_o   (rd_bcd)
  );

  assign rd_empty = empty_q;

endmodule

// File: tb/tb_interval_meter.sv
// Randomised and directed bench for interval_meter against a behavioural model
// of edge timestamps, best intervals and decimal readout.
module tb_interval_meter;

  localparam int TW  = 12;
  localparam int NCH = 4;
  localparam int DIG = 3;
  localparam int M   = 1 << TW;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                tick = 1'b0;
  logic [NCH-1:0]      evt = '0;
  logic                clr = 1'b0;
  logic                rd_req = 1'b0;
  logic [1:0]          rd_ch = '0;
  logic                rd_busy, rd_valid, rd_ovf, rd_empty;
  logic [4*DIG-1:0]    rd_bcd;
  logic [NCH*TW-1:0]   best;
  logic [NCH-1:0]      best_vld;

  int errors = 0;
  int checks = 0;

  interval_meter #(
    .TIME_W (TW),
    .N_CH   (NCH),
    .DIGITS (DIG)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .evt      (evt),
    .clr      (clr),
    .rd_req   (rd_req),
    .rd_ch    (rd_ch),
    .rd_busy  (rd_busy),
    .rd_valid (rd_valid),
    .rd_bcd   (rd_bcd),
    .rd_ovf   (rd_ovf),
    .rd_empty (rd_empty),
    .best     (best),
    .best_vld (best_vld)
  );

  always #5 clk = ~clk;

  // Behavioural model state.
  int m_now;
  bit m_prev[NCH], m_armed[NCH], m_vld[NCH];
  int m_last[NCH], m_best[NCH];
  int m_age;                      // cycles since accepted request, 0 = idle
  bit m_empty, m_res_ovf, m_ovf_out;
  int m_res_bcd, m_bcd_out;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic to_bcd(input int v, output int bcd, output bit ovf);
    int lim = 1;
    for (int k = 0; k < DIG; k++) lim *= 10;
    bcd = 0;
    ovf = (v >= lim);
    for (int k = 0; k < DIG; k++) begin
      bcd |= (ovf ? 9 : (v % 10)) << (4 * k);
      v /= 10;
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_now = 0;
      for (int i = 0; i < NCH; i++) begin
        m_prev[i] = 0; m_armed[i] = 0; m_vld[i] = 0; m_last[i] = 0; m_best[i] = 0;
      end
      m_age = 0; m_empty = 0; m_bcd_out = 0; m_ovf_out = 0;
    end else begin
      if (m_age != 0) begin
        m_age++;
        if (m_age > TW + 2) m_age = 0;
        else if (m_age == TW + 2) begin
          m_bcd_out = m_res_bcd;
          m_ovf_out = m_res_ovf;
        end
      end else if (rd_req) begin
        int ch;
        ch = int'(rd_ch);
        m_age   = 1;
        m_empty = !(ch < NCH && m_vld[ch]);
        to_bcd(m_empty ? 0 : m_best[ch], m_res_bcd, m_res_ovf);
      end
      for (int i = 0; i < NCH; i++) begin
        bit rise;
        rise = evt[i] && !m_prev[i];
        m_prev[i] = evt[i];
        if (clr) begin
          m_armed[i] = 0; m_vld[i] = 0; m_best[i] = 0;
        end else if (rise) begin
          if (m_armed[i]) begin
            int d;
            d = (m_now - m_last[i] + M) % M;
            if (!m_vld[i] || d <= m_best[i]) begin
              m_best[i] = d;
              m_vld[i]  = 1;
            end
          end
          m_last[i]  = m_now;
          m_armed[i] = 1;
        end
      end
      if (tick) m_now = (m_now + 1) % M;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      chk($sformatf("best[%0d]", i), 32'(best[i*TW +: TW]), 32'(m_best[i]));
      chk($sformatf("best_vld[%0d]", i), 32'(best_vld[i]), 32'(m_vld[i]));
    end
    chk("rd_busy", 32'(rd_busy), 32'(m_age != 0));
    chk("rd_valid", 32'(rd_valid), 32'(m_age == TW + 2));
    chk("rd_empty", 32'(rd_empty), 32'(m_empty));
    if (m_age == 0 || m_age == TW + 2) begin
      chk("rd_bcd", 32'(rd_bcd), 32'(m_bcd_out));
      chk("rd_ovf", 32'(rd_ovf), 32'(m_ovf_out));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Literal check of both the DUT and the model.
  task automatic lit(input string name, input int dut_v, input int model_v, input int exp);
    chk({name, "_model"}, 32'(model_v), 32'(exp));
    chk(name, 32'(dut_v), 32'(exp));
  endtask

  task automatic goto_now(input int t);
    int g = 0;
    t = t % M;
    while (m_now != t && g < 2 * M) begin
      cyc();
      g++;
    end
    chk("goto_now_reached", 32'(m_now), 32'(t));
  endtask

  task automatic pulse(input int ch);
    evt[ch] = 1'b1;
    cyc();
    evt[ch] = 1'b0;
  endtask

  // Issue a read; optionally a second request in cycle extra_at. Returns the
  // cycle number (relative to the request) at which rd_valid was first seen.
  task automatic do_read(input int ch, input int extra_at, output int vc);
    int n = 1;
    rd_ch  = 2'(ch);
    rd_req = 1'b1;
    cyc();
    rd_req = 1'b0;
    while (!rd_valid && n < 40) begin
      if (n == extra_at) begin
        rd_ch  = 2'(0);
        rd_req = 1'b1;
      end
      cyc();
      rd_req = 1'b0;
      n++;
    end
    vc = n;
  endtask

  initial begin
    int vc, t;
    repeat (3) cyc();
    lit("reset_best", int'(best), m_best[0], 0);
    lit("reset_vld", int'(best_vld), int'(m_vld[0]), 0);
    chk("reset_busy", 32'(rd_busy), 32'd0);
    rst  = 1'b0;
    tick = 1'b1;

    goto_now(100); pulse(0);
    goto_now(350); pulse(0);
    goto_now(500); pulse(0);
    lit("ch0_best150", int'(best[0 +: TW]), m_best[0], 150);
    lit("ch0_vld", int'(best_vld[0]), int'(m_vld[0]), 1);
    lit("ch1_vld", int'(best_vld[1]), int'(m_vld[1]), 0);

    goto_now(M - 10); pulse(2);
    goto_now(5); pulse(2);
    lit("ch2_wrap15", int'(best[2*TW +: TW]), m_best[2], 15);

    evt[0] = 1'b1;
    clr    = 1'b1;
    cyc();
    clr    = 1'b0;
    evt[0] = 1'b0;
    lit("clr_vld0", int'(best_vld[0]), int'(m_vld[0]), 0);
    lit("clr_best0", int'(best[0 +: TW]), m_best[0], 0);
    t = m_now + 3;
    goto_now(t); pulse(0);
    goto_now(t + 40); pulse(0);
    lit("ch0_best40", int'(best[0 +: TW]), m_best[0], 40);

    t = m_now + 5;
    goto_now(t); pulse(3);
    goto_now(t + 987); pulse(3);
    lit("ch3_best987", int'(best[3*TW +: TW]), m_best[3], 987);
    do_read(3, 5, vc);
    chk("read3_latency", 32'(vc), 32'(TW + 2));
    chk("read3_bcd", 32'(rd_bcd), 32'h987);
    chk("read3_ovf", 32'(rd_ovf), 32'd0);
    cyc();
    chk("second_req_ignored", 32'(rd_busy), 32'd0);

    do_read(1, 0, vc);
    chk("read1_empty", 32'(rd_empty), 32'd1);
    chk("read1_bcd", 32'(rd_bcd), 32'd0);
    t = m_now + 5;
    goto_now(t); pulse(1);
    goto_now(t + 1500); pulse(1);
    do_read(1, 0, vc);
    chk("read1_ovf", 32'(rd_ovf), 32'd1);
    chk("read1_sat", 32'(rd_bcd), 32'h999);
    chk("read1_not_empty", 32'(rd_empty), 32'd0);
    cyc();

    rd_ch  = 2'(0);
    rd_req = 1'b1;
    cyc();
    rd_req = 1'b0;
    repeat (9) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_busy", 32'(rd_busy), 32'd0);
    chk("rst_vld", 32'(best_vld), 32'd0);
    vc = 0;
    repeat (20) begin
      if (rd_valid) vc++;
      cyc();
    end
    chk("rst_no_valid", 32'(vc), 32'd0);

    repeat (3000) begin
      for (int i = 0; i < NCH; i++) if ($urandom_range(0, 7) == 0) evt[i] = ~evt[i];
      tick   = ($urandom_range(0, 9) < 8);
      clr    = ($urandom_range(0, 199) == 0);
      rd_req = ($urandom_range(0, 15) == 0);
      rd_ch  = 2'($urandom_range(0, 3));
      cyc();
    end
    evt = '0; clr = 1'b0; rd_req = 1'b0;
    repeat (30) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
